uart_rx_fifo: RTL and testbench

Oversampling UART receiver with a parametrised frame format and a built-in receive FIFO. It pairs with the existing oversample baud generator and `uart_tx`. It recovers serial frames from `rx_serial` using 3-sample majority voting around each bit centre, and checks the start, stop and (optionally) parity bits. Received words are buffered, together with their error flags, in a first-word-fall-through FIFO with a valid/ready read port.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receiver and transmitter.
// Holds the default frame format and the receiver FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS_DEFAULT  = 8;
    localparam int UART_OVERSAMPLE_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // 3-input majority used by the bit-centre voter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic first-word-fall-through FIFO with a valid/ready read port.
// A push into a full FIFO is still accepted when a pop happens on the same
// edge; otherwise it is dropped and reported on 'dropped' for one cycle.
// The head word reads as zero whenever the FIFO is empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_word,
    input  logic                         pop_ready,
    output logic [WIDTH-1:0]             head_word,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         dropped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full       = (count == CNT_FULL);
    assign head_valid = (count != '0);
    assign pop        = head_valid && pop_ready;
    assign wr_en      = push && (!full || pop);
    assign dropped    = push && full && !pop;
    assign head_word  = head_valid ? mem[rd_ptr] : '0;

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a built-in FWFT receive FIFO.
// Each bit is the majority of three samples around its centre; start, stop
// and optional parity bits are checked and stored alongside the data word.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synced line
// START  | validating the start bit (false starts fall back to IDLE)
// DATA   | shifting in data bits, LSB first
// PARITY | sampling and checking the parity bit (parity builds only)
// STOP   | checking the stop bit; pushes the word at the bit centre
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              os_tick,
    input  logic                              rx_serial,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_frame_err,
    output logic                              rd_parity_err,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    input  logic                              overrun_clr,
    output logic                              busy
);

    localparam int OC_W   = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int MID    = OVERSAMPLE / 2;
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [OC_W-1:0]  OC_SAMP_A = OC_W'(MID - 1);
    localparam logic [OC_W-1:0]  OC_SAMP_B = OC_W'(MID);
    localparam logic [OC_W-1:0]  OC_DECIDE = OC_W'(MID + 1);
    localparam logic [OC_W-1:0]  OC_LAST   = OC_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_rx_state_t       state;
    uart_rx_state_t       state_next;
    logic                 sync_1;
    logic                 sync_2;
    logic                 rx_prev;
    logic [OC_W-1:0]      oc;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp_a;
    logic                 samp_b;
    logic                 maj;
    logic                 at_decide;
    logic                 at_wrap;
    logic                 push;
    logic                 parity_bit;
    logic [WORD_W-1:0]    push_word;
    logic [WORD_W-1:0]    head_word;
    logic                 drop;

    assign at_decide = (oc == OC_DECIDE);
    assign at_wrap   = (oc == OC_LAST);
    assign maj       = maj3(samp_a, samp_b, sync_2);
    assign busy      = (state != IDLE);

    // Two-flop synchroniser on the asynchronous serial input; idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= rx_serial;
            sync_2 <= sync_1;
        end
    end

    // FSM state register plus the previous tick's line sample for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rx_prev <= 1'b1;
        end else begin
            state <= state_next;
            if (os_tick) begin
                rx_prev <= sync_2;
            end
        end
    end

    // Next-state logic; everything advances only on oversample ticks
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (os_tick) begin
            case (state)
                IDLE: begin
                    if (rx_prev && !sync_2) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (at_decide && maj) begin
                        state_next = IDLE;
                    end else if (at_wrap) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (at_wrap && (idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_wrap) begin
                        state_next = STOP;
                    end
                end
`endif
                STOP: begin
                    // Return early so the next start edge is seen even with drift
                    if (at_decide) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Tick counter, centre samples, bit index and data shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oc     <= '0;
            idx    <= '0;
            shreg  <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (os_tick) begin
            if (state == IDLE || state_next != state || at_wrap) begin
                oc <= '0;
            end else begin
                oc <= oc + 1'b1;
            end
            if (oc == OC_SAMP_A) begin
                samp_a <= sync_2;
            end
            if (oc == OC_SAMP_B) begin
                samp_b <= sync_2;
            end
            if (state == START) begin
                idx <= '0;
            end else if (state == DATA && at_wrap) begin
                idx <= idx + 1'b1;
            end
            if (state == DATA && at_decide) begin
                shreg[idx] <= maj;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic parity_err;

    // Parity check: data XOR parity bit must equal the configured sense
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (os_tick && state == PARITY && at_decide) begin
            parity_err <= ((^shreg) ^ maj) != PAR_ODD;
        end
    end

    assign parity_bit    = parity_err;
    assign rd_parity_err = head_word[WORD_W-1];
`else
    logic unused_parity_cfg;

    assign parity_bit        = 1'b0;
    assign rd_parity_err     = 1'b0;
    assign unused_parity_cfg = (PARITY_ODD != 0) | head_word[WORD_W-1];
`endif

    assign push_word = {parity_bit, ~maj, shreg};

    uart_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_word  (push_word),
        .pop_ready  (rd_ready),
        .head_word  (head_word),
        .head_valid (rd_valid),
        .count      (fifo_count),
        .dropped    (drop)
    );

    assign rd_data      = head_word[DATA_BITS-1:0];
    assign rd_frame_err = head_word[DATA_BITS];

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
// Frames are driven aligned to an oversample tick (os_tick every 4 clk,
// 8 ticks per bit), so the stop-bit decision edge is known in advance.
// Honours UART_RX_PARITY_EN for the frame length and parity expectations.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
    localparam int NB        = 9;
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam int NB        = 8;
    localparam bit PAR_BUILD = 1'b0;
`endif
    // Detect at tick 1, decision at tick 15 + 8*NB after the aligned tick, 4 clk per tick
    localparam int PUSH_OFS = 4 * (15 + 8 * NB);

    logic       clk;
    logic       rst;
    logic       os_tick;
    logic       rx_serial;
    logic [7:0] rd_data;
    logic       rd_frame_err;
    logic       rd_parity_err;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       overrun_clr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tdiv   = 0;
    int frame_n0 = 0;
    logic       pre_valid, post_valid;
    logic [2:0] pre_count, post_count;

    typedef struct {
        logic [8:0] bits;
        logic       stop;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    uart_rx_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .os_tick       (os_tick),
        .rx_serial     (rx_serial),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        os_tick = 1'b0;
        forever begin
            @(negedge clk);
            tdiv    = (tdiv + 1) % 4;
            os_tick = (tdiv == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hook(input bit pop_at_push);
        if (cyc == frame_n0 + PUSH_OFS - 1) begin
            pre_valid = rd_valid;
            pre_count = fifo_count;
        end
        if (cyc == frame_n0 + PUSH_OFS) begin
            post_valid = rd_valid;
            post_count = fifo_count;
        end
        if (pop_at_push) rd_ready = (cyc == frame_n0 + PUSH_OFS - 1);
    endtask

    task automatic wait_clks(input int n, input bit pop_at_push);
        repeat (n) begin
            @(negedge clk);
            hook(pop_at_push);
        end
    endtask

    // Returns at the negedge just after a tick edge
    task automatic align;
        @(posedge clk);
        while (!os_tick) @(posedge clk);
        @(negedge clk);
        frame_n0 = cyc;
    endtask

    task automatic send_frame(input logic [8:0] bits, input logic stop, input bit pop_at_push);
        align();
        rx_serial = 1'b0;
        wait_clks(BIT_CLKS, pop_at_push);
        for (int i = 0; i < NB; i++) begin
            rx_serial = bits[i];
            wait_clks(BIT_CLKS, pop_at_push);
        end
        rx_serial = stop;
        wait_clks(BIT_CLKS, pop_at_push);
        rx_serial = 1'b1;
        wait_clks(2 * BIT_CLKS, pop_at_push);
    endtask

    task automatic pop_one;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        vecs[0] = '{9'h0A5, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{9'h03C, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{9'h011, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{9'h107, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{9'h007, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[5] = '{9'h000, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{9'h0FF, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{9'h180, 1'b1, 8'h80, 1'b0, 1'b0};

        rst = 1'b1;
        rx_serial = 1'b1;
        rd_ready = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", rd_valid, 0);
        check("reset_data", rd_data, 0);
        check("reset_count", fifo_count, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Table-driven single frames: push latency, contents, pop back to empty
        for (int v = 0; v < NV; v++) begin
            send_frame(vecs[v].bits, vecs[v].stop, 1'b0);
            check($sformatf("v%0d_pre_valid", v), pre_valid, 0);
            check($sformatf("v%0d_post_valid", v), post_valid, 1);
            check($sformatf("v%0d_post_count", v), post_count, 1);
            check($sformatf("v%0d_data", v), rd_data, vecs[v].data);
            check($sformatf("v%0d_ferr", v), rd_frame_err, vecs[v].ferr);
            check($sformatf("v%0d_perr", v), rd_parity_err, PAR_BUILD ? vecs[v].perr : 1'b0);
            check($sformatf("v%0d_busy", v), busy, 0);
            pop_one();
            check($sformatf("v%0d_pop_valid", v), rd_valid, 0);
            check($sformatf("v%0d_pop_data", v), rd_data, 0);
            check($sformatf("v%0d_pop_count", v), fifo_count, 0);
        end

        // Glitch: 2-tick low pulse starts the FSM, which then rejects it
        align();
        rx_serial = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i == 7) rx_serial = 1'b1;
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_rise", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (!busy) seen = 1'b1;
            else @(negedge clk);
        end
        check("glitch_busy_fall", seen, 1);
        repeat (64) @(negedge clk);
        check("glitch_count", fifo_count, 0);
        check("glitch_busy_idle", busy, 0);

        // Overrun: five words into a four-deep FIFO
        for (int k = 1; k <= 5; k++) send_frame({1'b0, 8'(k)}, 1'b1, 1'b0);
        check("ovr_count", fifo_count, 4);
        check("ovr_flag", overrun, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovr_pop%0d", k), rd_data, k);
            pop_one();
        end
        check("ovr_empty", rd_valid, 0);
        check("ovr_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clear", overrun, 0);

        // Full FIFO with push and pop on the same edge: no drop, count unchanged
        for (int k = 1; k <= 4; k++) send_frame({1'b0, 8'(8'h20 + k)}, 1'b1, 1'b0);
        check("pp_full", fifo_count, 4);
        send_frame(9'h025, 1'b1, 1'b1);
        check("pp_pre_count", pre_count, 4);
        check("pp_post_count", post_count, 4);
        check("pp_overrun", overrun, 0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pp_pop%0d", k), rd_data, 8'h20 + k);
            pop_one();
        end
        check("pp_empty", fifo_count, 0);

        // Reset in the middle of a frame discards it and the FIFO contents
        send_frame(9'h05A, 1'b1, 1'b0);
        check("rmf_prefill", fifo_count, 1);
        align();
        rx_serial = 1'b0;
        wait_clks(BIT_CLKS, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rx_serial = (i < 2);
            wait_clks(BIT_CLKS, 1'b0);
        end
        check("rmf_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rmf_valid", rd_valid, 0);
        check("rmf_data", rd_data, 0);
        check("rmf_count", fifo_count, 0);
        check("rmf_busy", busy, 0);
        check("rmf_ferr", rd_frame_err, 0);
        check("rmf_perr", rd_parity_err, 0);
        check("rmf_overrun", overrun, 0);
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        send_frame(9'h0C3, 1'b1, 1'b0);
        check("rmf_after_count", fifo_count, 1);
        check("rmf_after_data", rd_data, 8'hC3);
        check("rmf_after_ferr", rd_frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
